// File: rtl/key_sched_pkg.sv
// Shared definitions for the key scheduler slice.
// Holds the FSM state type, the default Galois feedback mask for
// x^32+x^22+x^2+x+1, the zero-seed substitute and the single-step LFSR function.
package key_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REKEY = 2'd2
  } state_t;

  localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h8020_0003;
  localparam logic [31:0] SEED_ZERO_SUBST   = 32'h0000_0001;

  // One Galois step: shift right, fold the mask in when the bit shifted out was 1.
  function automatic logic [31:0] lfsr_next(input logic [31:0] cur,
                                            input logic [31:0] taps);
    return cur[0] ? ((cur >> 1) ^ taps) : (cur >> 1);
  endfunction

endpackage

// File: rtl/key_scheduler_lfsr32.sv
// 32-bit Galois LFSR register.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset, clears the register to 0
//   load     - load load_val this cycle (has priority over step)
//   load_val - value to load
//   step     - advance the register by one Galois step
//   q        - current register value
module lfsr32
  import key_sched_pkg::*;
#(
  parameter logic [31:0] TAPS = LFSR_TAPS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= lfsr_next(q, TAPS);
    end
  end

endmodule

// File: rtl/key_scheduler.sv
// Key scheduler: accepts a seed, then streams LFSR-generated key words with a
// valid/ready handshake, rekeying automatically every REKEY_INTERVAL transfers
// from the stored seed rotated left by one.
// Ports:
//   clk, rst       - clock and synchronous active-high reset
//   seed_valid     - seed qualifier
//   seed[31:0]     - seed word
//   seed_ready     - a seed can be accepted (IDLE and RUN)
//   key_valid      - key qualifier (RUN only)
//   key[31:0]      - current key word (the LFSR register)
//   key_ready      - downstream takes key this cycle
//   enabled        - mirror of key_valid for the downstream xorer
//   key_count[15:0]- key transfers in the current epoch
//   seed_zero_err  - last accepted seed was zero (substituted by 1)
module key_scheduler
  import key_sched_pkg::*;
#(
  parameter int unsigned REKEY_INTERVAL = 256,
  parameter logic [31:0] LFSR_TAPS      = LFSR_TAPS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_valid,
  input  logic [31:0] seed,
  output logic        seed_ready,
  output logic        key_valid,
  output logic [31:0] key,
  input  logic        key_ready,
  output logic        enabled,
  output logic [15:0] key_count,
  output logic        seed_zero_err
);

  localparam logic [15:0] LAST_COUNT = 16'(REKEY_INTERVAL - 1);

  state_t      state_q, state_d;
  logic [31:0] stored_seed;
  logic [31:0] seed_eff;
  logic [31:0] seed_rot;
  logic [31:0] lfsr_load_val;
  logic [31:0] lfsr_q;
  logic        seed_xfer;
  logic        key_xfer;
  logic        epoch_end;
  logic        lfsr_load;

  assign key_valid  = (state_q == RUN);
  assign seed_ready = (state_q != REKEY);
  assign enabled    = key_valid;
  assign key        = lfsr_q;

  assign seed_xfer = seed_valid && seed_ready;
  assign key_xfer  = key_valid && key_ready;
  assign epoch_end = key_xfer && (key_count == LAST_COUNT);

  // A zero seed would lock the LFSR at zero; substitute 1 instead.
  assign seed_eff = (seed == '0) ? SEED_ZERO_SUBST : seed;
  assign seed_rot = {stored_seed[30:0], stored_seed[31]};

  // Seed load overrides the step in lfsr32, so a simultaneous seed and key
  // transfer leaves the new seed in the register.
  assign lfsr_load     = seed_xfer || (state_q == REKEY);
  assign lfsr_load_val = (state_q == REKEY) ? seed_rot : seed_eff;

  lfsr32 #(
    .TAPS(LFSR_TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .load_val(lfsr_load_val),
    .step    (key_xfer),
    .q       (lfsr_q)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (seed_xfer) state_d = RUN;
      RUN: begin
        if (seed_xfer)      state_d = RUN;
        else if (epoch_end) state_d = REKEY;
      end
      REKEY:   state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      stored_seed   <= '0;
      key_count     <= '0;
      seed_zero_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (seed_xfer) begin
        stored_seed   <= seed_eff;
        key_count     <= '0;
        seed_zero_err <= (seed == '0);
      end else if (state_q == REKEY) begin
        stored_seed <= seed_rot;
      end else if (key_xfer) begin
        key_count <= epoch_end ? '0 : key_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_key_scheduler.sv
module tb_key_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_valid = 1'b0;
  logic [31:0] seed = '0;
  logic        key_ready = 1'b0;

  // index 0: default interval (256); index 1: interval 2
  logic        o_sr  [2];
  logic        o_kv  [2];
  logic        o_en  [2];
  logic        o_err [2];
  logic [31:0] o_key [2];
  logic [15:0] o_cnt [2];

  key_scheduler dut_a (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
    .seed_ready(o_sr[0]), .key_valid(o_kv[0]), .key(o_key[0]),
    .key_ready(key_ready), .enabled(o_en[0]), .key_count(o_cnt[0]),
    .seed_zero_err(o_err[0])
  );

  key_scheduler #(.REKEY_INTERVAL(2)) dut_b (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
    .seed_ready(o_sr[1]), .key_valid(o_kv[1]), .key(o_key[1]),
    .key_ready(key_ready), .enabled(o_en[1]), .key_count(o_cnt[1]),
    .seed_zero_err(o_err[1])
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam logic [31:0] TAPS = 32'h8020_0003;

  // Reference model: plain variables following the rules directly.
  int unsigned m_iv [2] = '{256, 2};
  bit          m_run   [2];
  bit          m_rekey [2];
  bit          m_err   [2];
  logic [31:0] m_lfsr  [2];
  logic [31:0] m_stored[2];
  int unsigned m_cnt   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_step(input int i, input bit r, input bit sv,
                                 input logic [31:0] sd, input bit kr);
    bit ev;
    bit sr;
    ev = m_run[i] && !m_rekey[i];
    sr = !m_rekey[i];
    if (r) begin
      m_run[i] = 0; m_rekey[i] = 0; m_err[i] = 0;
      m_lfsr[i] = '0; m_stored[i] = '0; m_cnt[i] = 0;
    end else if (m_rekey[i]) begin
      m_stored[i] = (m_stored[i] << 1) | (m_stored[i] >> 31);
      m_lfsr[i]   = m_stored[i];
      m_rekey[i]  = 0;
    end else if (sv && sr) begin
      m_lfsr[i]   = (sd == 0) ? 32'd1 : sd;
      m_stored[i] = m_lfsr[i];
      m_err[i]    = (sd == 0);
      m_cnt[i]    = 0;
      m_run[i]    = 1;
    end else if (ev && kr) begin
      if (m_lfsr[i] % 2 == 1) m_lfsr[i] = (m_lfsr[i] / 2) ^ TAPS;
      else                    m_lfsr[i] = m_lfsr[i] / 2;
      if (m_cnt[i] + 1 == m_iv[i]) begin
        m_cnt[i]   = 0;
        m_rekey[i] = 1;
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  endfunction

  task automatic check_model(input int i);
    bit ev;
    ev = m_run[i] && !m_rekey[i];
    check($sformatf("model%0d.key_valid", i), 32'(o_kv[i]), 32'(ev));
    check($sformatf("model%0d.enabled", i), 32'(o_en[i]), 32'(ev));
    check($sformatf("model%0d.seed_ready", i), 32'(o_sr[i]), 32'(!m_rekey[i]));
    check($sformatf("model%0d.key", i), o_key[i], m_lfsr[i]);
    check($sformatf("model%0d.key_count", i), 32'(o_cnt[i]), m_cnt[i]);
    check($sformatf("model%0d.seed_zero_err", i), 32'(o_err[i]), 32'(m_err[i]));
  endtask

  task automatic tick(input bit r, input bit sv, input logic [31:0] sd, input bit kr);
    rst = r; seed_valid = sv; seed = sd; key_ready = kr;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_step(i, r, sv, sd, kr);
      check_model(i);
    end
  endtask

  typedef struct {
    bit          r;
    bit          sv;
    logic [31:0] sd;
    bit          kr;
    bit          ekv;
    bit          esr;
    logic [31:0] ekey;
    logic [15:0] ecnt;
    bit          eerr;
  } vec_t;

  vec_t vq[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table for dut_a (interval 256): expected outputs after each cycle.
    vq.push_back('{1, 0, 32'h0,         0, 0, 1, 32'h0,         16'd0, 0}); // reset
    vq.push_back('{0, 1, 32'h1,         0, 1, 1, 32'h0000_0001, 16'd0, 0}); // seed 1
    vq.push_back('{0, 0, 32'h0,         1, 1, 1, 32'h8020_0003, 16'd1, 0});
    vq.push_back('{0, 0, 32'h0,         1, 1, 1, 32'hC030_0002, 16'd2, 0});
    vq.push_back('{0, 0, 32'h0,         1, 1, 1, 32'h6018_0001, 16'd3, 0});
    vq.push_back('{1, 0, 32'h0,         1, 0, 1, 32'h0,         16'd0, 0}); // rst mid-RUN
    vq.push_back('{0, 0, 32'h0,         1, 0, 1, 32'h0,         16'd0, 0}); // stays idle
    vq.push_back('{0, 1, 32'h0,         0, 1, 1, 32'h0000_0001, 16'd0, 1}); // zero seed
    vq.push_back('{0, 1, 32'h5,         0, 1, 1, 32'h0000_0005, 16'd0, 0});
    vq.push_back('{0, 1, 32'h1,         1, 1, 1, 32'h0000_0001, 16'd0, 0}); // seed wins
    vq.push_back('{0, 0, 32'h0,         1, 1, 1, 32'h8020_0003, 16'd1, 0});
    for (int k = 0; k < 5; k++)
      vq.push_back('{0, 0, 32'h0,       0, 1, 1, 32'h8020_0003, 16'd1, 0}); // stall
    vq.push_back('{0, 0, 32'h0,         1, 1, 1, 32'hC030_0002, 16'd2, 0});
    vq.push_back('{1, 0, 32'h0,         1, 0, 1, 32'h0,         16'd0, 0});
    vq.push_back('{0, 0, 32'h0,         0, 0, 1, 32'h0,         16'd0, 0});

    foreach (vq[k]) begin
      tick(vq[k].r, vq[k].sv, vq[k].sd, vq[k].kr);
      check($sformatf("vec%0d.key_valid", k), 32'(o_kv[0]), 32'(vq[k].ekv));
      check($sformatf("vec%0d.enabled", k), 32'(o_en[0]), 32'(vq[k].ekv));
      check($sformatf("vec%0d.seed_ready", k), 32'(o_sr[0]), 32'(vq[k].esr));
      check($sformatf("vec%0d.key", k), o_key[0], vq[k].ekey);
      check($sformatf("vec%0d.key_count", k), 32'(o_cnt[0]), 32'(vq[k].ecnt));
      check($sformatf("vec%0d.seed_zero_err", k), 32'(o_err[0]), 32'(vq[k].eerr));
    end

    // Rekey with interval 2 on dut_b.
    tick(1, 0, 32'h0, 0);
    tick(0, 1, 32'h1, 0);
    check("rk.first_key", o_key[1], 32'h0000_0001);
    check("rk.first_valid", 32'(o_kv[1]), 32'd1);
    tick(0, 0, 32'h0, 1);
    check("rk.second_key", o_key[1], 32'h8020_0003);
    check("rk.second_cnt", 32'(o_cnt[1]), 32'd1);
    tick(0, 0, 32'h0, 1);
    check("rk.rekey_valid", 32'(o_kv[1]), 32'd0);
    check("rk.rekey_seed_ready", 32'(o_sr[1]), 32'd0);
    check("rk.rekey_enabled", 32'(o_en[1]), 32'd0);
    check("rk.rekey_cnt", 32'(o_cnt[1]), 32'd0);
    tick(0, 0, 32'h0, 0);
    check("rk.after_key", o_key[1], 32'h0000_0002);
    check("rk.after_valid", 32'(o_kv[1]), 32'd1);
    check("rk.after_cnt", 32'(o_cnt[1]), 32'd0);
    // Seed at the epoch's last transfer: no rekey cycle.
    tick(0, 0, 32'h0, 1);
    check("sw.step_key", o_key[1], 32'h0000_0001);
    check("sw.step_cnt", 32'(o_cnt[1]), 32'd1);
    tick(0, 1, 32'hABCD_1234, 1);
    check("sw.key", o_key[1], 32'hABCD_1234);
    check("sw.valid", 32'(o_kv[1]), 32'd1);
    check("sw.cnt", 32'(o_cnt[1]), 32'd0);
    tick(0, 0, 32'h0, 0);
    check("sw.no_rekey", 32'(o_kv[1]), 32'd1);
    // Reset during REKEY overrides a pending seed.
    tick(0, 0, 32'h0, 1);
    tick(0, 0, 32'h0, 1);
    check("rr.in_rekey", 32'(o_sr[1]), 32'd0);
    tick(1, 1, 32'h7, 1);
    check("rr.valid", 32'(o_kv[1]), 32'd0);
    check("rr.key", o_key[1], 32'h0);
    check("rr.seed_ready", 32'(o_sr[1]), 32'd1);
    tick(0, 0, 32'h0, 1);
    check("rr.idle", 32'(o_kv[1]), 32'd0);

    // Randomized traffic against the model for both instances.
    for (int n = 0; n < 4000; n++) begin
      bit          r, sv, kr;
      logic [31:0] sd;
      r  = ($urandom_range(0, 199) == 0);
      sv = ($urandom_range(0, 7) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom());
      kr = ($urandom_range(0, 3) != 0);
      tick(r, sv, sd, kr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 Parameter REKEY_INTERVAL, default 256, SHALL set the key transfers per epoch before automatic rekey (legal range 1..65535).
REQ-002 Parameter LFSR_TAPS, default 32'h8020_0003, SHALL set the Galois feedback mask for x^32+x^22+x^2+x+1.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 seed_valid  input  1  SHALL qualify seed.
REQ-006 seed  input  32  SHALL carry the seed word.
REQ-007 seed_ready  output  1  SHALL indicate a seed can be accepted.
REQ-008 key_valid  output  1  SHALL qualify key.
REQ-009 key  output  32  SHALL carry the current key word to the downstream xorer key input.
REQ-010 key_ready  input  1  SHALL indicate the downstream consumer takes key this cycle.
REQ-011 enabled  output  1  SHALL equal key_valid and drive the downstream xorer enabled input.
REQ-012 key_count  output  16  SHALL count key transfers in the current epoch.
REQ-013 seed_zero_err  output  1  SHALL flag that the last accepted seed was zero.

Function
REQ-014 States SHALL be IDLE, RUN and REKEY.
REQ-015 IDLE: key_valid=0, seed_ready=1; RUN: key_valid=1, seed_ready=1; REKEY: key_valid=0, seed_ready=0.
REQ-016 A seed transfer (seed_valid && seed_ready) SHALL, next cycle, load lfsr and stored_seed with seed, clear key_count, enter RUN.
REQ-017 A zero seed SHALL be replaced by 32'h0000_0001 and set seed_zero_err; a nonzero seed SHALL clear seed_zero_err.
REQ-018 key SHALL equal the lfsr register; latency from seed transfer to first key_valid is 1 cycle.
REQ-019 A key transfer (key_valid && key_ready) SHALL advance lfsr: lsb=1 -> (lfsr>>1)^LFSR_TAPS, lsb=0 -> lfsr>>1; key_count += 1.
REQ-020 While key_valid && !key_ready, key SHALL hold stable.
REQ-021 A key transfer with key_count == REKEY_INTERVAL-1 SHALL enter REKEY and clear key_count.
REQ-022 REKEY SHALL last exactly 1 cycle, set stored_seed and lfsr to stored_seed rotated left by 1, then return to RUN.
REQ-023 A simultaneous seed transfer and key transfer SHALL complete both; seed load wins: lfsr=new seed, key_count=0, no REKEY entered.
REQ-024 key_count arithmetic SHALL be 16-bit unsigned; never exceeds REKEY_INTERVAL-1.
REQ-025 The lfsr SHALL never hold zero in RUN.

Reset
REQ-026 rst SHALL force IDLE, lfsr=0, stored_seed=0, key=0, key_valid=0, enabled=0, seed_ready=1, key_count=0, seed_zero_err=0.
REQ-027 rst asserted mid-RUN or mid-REKEY SHALL override all transfers that cycle; no key emitted until a new seed.

Structure
REQ-028 Package key_sched_pkg SHALL hold the state enum, the LFSR_TAPS default constant and the lfsr_next function.
REQ-029 A sub-module lfsr32 SHALL hold the 32-bit register, step enable and load port; FSM and counters stay in key_scheduler.

Verification
REQ-030 Seed 32'h0000_0001, key_ready=1 -> keys 32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001 on consecutive cycles.
REQ-031 Seed 32'h0 -> first key 32'h0000_0001, seed_zero_err=1; then seed 32'h5 -> seed_zero_err=0, key 32'h0000_0005.
REQ-032 After first key, key_ready=0 for 5 cycles -> key holds 32'h8020_0003, key_count stays 1.
REQ-033 REKEY_INTERVAL=2, seed 32'h1 -> keys 32'h1, 32'h8020_0003, one cycle key_valid=0/seed_ready=0, then key 32'h0000_0002, key_count=0.
REQ-034 Seed transfer in the same cycle as key transfer of count REKEY_INTERVAL-1 -> no REKEY cycle; next key equals new seed, key_count=0.
REQ-035 rst pulsed mid-RUN -> next cycle key_valid=0, enabled=0, key=0, key_count=0; stays IDLE until seed.
